// File: rtl/rsa_host_sequencer_if.sv
// rsa_host_sequencer_if: bundles the host byte streams, the engine command
// interface and the status outputs of the host sequencer.
interface rsa_host_sequencer_if #(
    parameter int WIDTH = 32
);
    // Host byte-in stream
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    // Host byte-out stream
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    // Engine controller command interface
    logic [WIDTH-1:0] operand;
    logic [2:0]       input_data_type;
    logic             done;
    logic [WIDTH-1:0] result;
    // Status
    logic             busy;
    logic             error;
    logic [1:0]       err_code;

    // Sequencer side
    modport master (
        input  in_byte, in_valid, out_ready, done, result,
        output in_ready, out_byte, out_valid, operand, input_data_type,
               busy, error, err_code
    );

    // Host and engine side
    modport slave (
        output in_byte, in_valid, out_ready, done, result,
        input  in_ready, out_byte, out_valid, operand, input_data_type,
               busy, error, err_code
    );
endinterface

// File: rtl/rsa_host_sequencer.sv
// rsa_host_sequencer: byte-serial host front end for the modular
// exponentiation engine. Assembles WIDTH-bit operands from host frames,
// issues single-cycle engine commands, waits for completion and streams the
// result back to the host MSB first. WIDTH must be a multiple of 8, >= 16.
module rsa_host_sequencer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                  clk,
    input logic                  rst_n,
    rsa_host_sequencer_if.master bus
);

    localparam int NBYTES = WIDTH / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TCW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_HDR  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ISSUE     = 3'd2,
        GAP       = 3'd3,
        WAIT_DONE = 3'd4,
        SEND      = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [1:0]       code_q;       // command code from the accepted header
    logic [BCW-1:0]   byte_cnt;     // payload / result byte index
    logic [TCW-1:0]   tmo_cnt;      // cycles elapsed since the message was issued
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] shift_q;      // result shift register, MSB byte goes out first
    logic             error_q;
    logic [1:0]       err_code_q;

    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;
    logic [2:0]       idt_c;
    logic [7:0]       out_byte_c;

    logic             in_fire;
    logic             out_fire;
    logic             hdr_legal;
    logic             last_byte;
    logic             tmo_hit;

    // in_ready is held low for as long as reset is asserted, independent of the clock
    assign in_ready_c  = rst_n && ((state == IDLE) || (state == LOAD));
    assign out_valid_c = (state == SEND);

    assign in_fire   = bus.in_valid && in_ready_c;
    assign out_fire  = out_valid_c && bus.out_ready;
    assign hdr_legal = (bus.in_byte == 8'h01) || (bus.in_byte == 8'h02) ||
                       (bus.in_byte == 8'h03);
    assign last_byte = (byte_cnt == LAST_BYTE);
    // Terminal count is reached in the cycle that makes TIMEOUT_CYCLES since ISSUE
    assign tmo_hit   = (tmo_cnt >= TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_next = state;
        busy_c     = (state != IDLE);
        idt_c      = 3'd0;
        out_byte_c = 8'd0;
        case (state)
            IDLE: begin
                if (in_fire && hdr_legal) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (in_fire && last_byte) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                idt_c = {1'b0, code_q};
                // Only a message starts a computation; N and E just need a spacer cycle
                state_next = (code_q == 2'd1) ? WAIT_DONE : GAP;
            end
            GAP: begin
                state_next = IDLE;
            end
            WAIT_DONE: begin
                // done takes priority over a coinciding terminal count
                if (bus.done) begin
                    state_next = SEND;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                out_byte_c = shift_q[WIDTH-1 -: 8];
                if (out_fire && last_byte) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand assembly, result shifting, timeout counting and error reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q     <= 2'd0;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            operand_q  <= '0;
            shift_q    <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        if (hdr_legal) begin
                            code_q     <= bus.in_byte[1:0];
                            err_code_q <= ERR_NONE;
                            byte_cnt   <= '0;
                        end else begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_HDR;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        operand_q <= {operand_q[WIDTH-9:0], bus.in_byte};
                        byte_cnt  <= last_byte ? '0 : byte_cnt + BCW'(1);
                    end
                end
                ISSUE: begin
                    // First WAIT_DONE cycle is the first cycle after ISSUE
                    tmo_cnt <= TCW'(1);
                end
                WAIT_DONE: begin
                    if (bus.done) begin
                        shift_q  <= bus.result;
                        byte_cnt <= '0;
                    end else if (tmo_hit) begin
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TMO;
                    end else begin
                        tmo_cnt <= tmo_cnt + TCW'(1);
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        shift_q  <= {shift_q[WIDTH-9:0], 8'h00};
                        byte_cnt <= last_byte ? '0 : byte_cnt + BCW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready        = in_ready_c;
    assign bus.out_valid       = out_valid_c;
    assign bus.out_byte        = out_byte_c;
    assign bus.operand         = operand_q;
    assign bus.input_data_type = idt_c;
    assign bus.busy            = busy_c;
    assign bus.error           = error_q;
    assign bus.err_code        = err_code_q;

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// tb_rsa_host_sequencer: directed bench for rsa_host_sequencer. A second
// instance with a short timeout shares all inputs and is observed only by
// the timeout scenario.
`timescale 1ns/1ps
module tb_rsa_host_sequencer;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   tests  = 0;
    int   failed = 0;

    rsa_host_sequencer_if #(.WIDTH(WIDTH)) bus ();
    rsa_host_sequencer_if #(.WIDTH(WIDTH)) bus_t ();

    rsa_host_sequencer #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    rsa_host_sequencer #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(16)) dut_t (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_t.master)
    );

    assign bus_t.in_byte   = bus.in_byte;
    assign bus_t.in_valid  = bus.in_valid;
    assign bus_t.out_ready = bus.out_ready;
    assign bus_t.done      = bus.done;
    assign bus_t.result    = bus.result;

    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the byte transferred
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            tests++; failed++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        tests++; if (bus.operand !== 32'h0) begin failed++; $display("FAIL rst_operand: got %h want 0", bus.operand); end
        tests++; if (bus.input_data_type !== 3'd0) begin failed++; $display("FAIL rst_idt: got %0d want 0", bus.input_data_type); end
        tests++; if (bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00) begin failed++; $display("FAIL rst_out: valid=%b byte=%h want 0/00", bus.out_valid, bus.out_byte); end
        tests++; if (bus.error !== 1'b0 || bus.err_code !== 2'b00) begin failed++; $display("FAIL rst_err: error=%b code=%b want 0/00", bus.error, bus.err_code); end
        tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failed++; $display("FAIL rst_release: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
    endtask

    task automatic test_n_load();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0D);
        // cycle T+1
        tests++; if (bus.input_data_type !== 3'd2) begin failed++; $display("FAIL n_idt_t1: got %0d want 2", bus.input_data_type); end
        tests++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin failed++; $display("FAIL n_ctrl_t1: in_ready=%b busy=%b want 0/1", bus.in_ready, bus.busy); end
        @(negedge clk);
        tests++; if (bus.input_data_type !== 3'd0 || bus.busy !== 1'b1) begin failed++; $display("FAIL n_gap_t2: idt=%0d busy=%b want 0/1", bus.input_data_type, bus.busy); end
        @(negedge clk);
        tests++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin failed++; $display("FAIL n_idle_t3: busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready); end
        tests++; if (bus.operand !== 32'h0000000D) begin failed++; $display("FAIL n_operand: got %h want 0000000d", bus.operand); end
    endtask

    task automatic test_message();
        logic [7:0] exp_b [4];
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h41);
        tests++; if (bus.input_data_type !== 3'd1) begin failed++; $display("FAIL msg_idt_t1: got %0d want 1", bus.input_data_type); end
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            tests++;
            if (bus.input_data_type !== 3'd0 || bus.out_valid !== 1'b0 || bus.operand !== 32'h00000041) begin
                failed++;
                $display("FAIL msg_wait_c%0d: idt=%0d out_valid=%b operand=%h want 0/0/00000041", c, bus.input_data_type, bus.out_valid, bus.operand);
            end
        end
        @(negedge clk);
        bus.done   = 1'b1;
        bus.result = 32'h12345678;
        @(negedge clk);
        bus.done   = 1'b0;
        bus.result = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_b[i]) begin
                failed++;
                $display("FAIL msg_out%0d: valid=%b byte=%h want 1/%h", i, bus.out_valid, bus.out_byte, exp_b[i]);
            end
            @(negedge clk);
        end
        tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failed++; $display("FAIL msg_end: out_valid=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
        tests++; if (bus.operand !== 32'h00000041) begin failed++; $display("FAIL msg_operand: got %h want 00000041", bus.operand); end
    endtask

    task automatic test_backpressure();
        logic [7:0] frame [5];
        int         gap [5];
        logic [7:0] exp_b [4];
        frame = '{8'h01, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        gap   = '{0, 2, 0, 1, 3};
        exp_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (gap[i]) @(negedge clk);
            send_byte(frame[i]);
        end
        tests++; if (bus.input_data_type !== 3'd1) begin failed++; $display("FAIL bp_idt: got %0d want 1", bus.input_data_type); end
        tests++; if (bus.operand !== 32'hABCDEF01) begin failed++; $display("FAIL bp_operand: got %h want abcdef01", bus.operand); end
        repeat (2) @(negedge clk);
        bus.done   = 1'b1;
        bus.result = 32'hCAFEF00D;
        @(negedge clk);
        bus.done   = 1'b0;
        bus.result = 32'h0;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'hCA) begin failed++; $display("FAIL bp_first: valid=%b byte=%h want 1/ca", bus.out_valid, bus.out_byte); end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'hCA) begin
                failed++;
                $display("FAIL bp_stall%0d: valid=%b byte=%h want 1/ca", s, bus.out_valid, bus.out_byte);
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_b[i]) begin
                failed++;
                $display("FAIL bp_out%0d: valid=%b byte=%h want 1/%h", i, bus.out_valid, bus.out_byte, exp_b[i]);
            end
            @(negedge clk);
        end
        tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failed++; $display("FAIL bp_end: out_valid=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_bad_header();
        send_byte(8'h07);
        tests++; if (bus.error !== 1'b1 || bus.err_code !== 2'b01) begin failed++; $display("FAIL bad_pulse: error=%b code=%b want 1/01", bus.error, bus.err_code); end
        tests++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin failed++; $display("FAIL bad_idle: busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready); end
        @(negedge clk);
        tests++; if (bus.error !== 1'b0 || bus.err_code !== 2'b01) begin failed++; $display("FAIL bad_sticky: error=%b code=%b want 0/01", bus.error, bus.err_code); end
        send_byte(8'h03);
        tests++; if (bus.err_code !== 2'b00 || bus.busy !== 1'b1) begin failed++; $display("FAIL bad_clear: code=%b busy=%b want 00/1", bus.err_code, bus.busy); end
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        tests++; if (bus.input_data_type !== 3'd3) begin failed++; $display("FAIL e_idt: got %0d want 3", bus.input_data_type); end
        tests++; if (bus.operand !== 32'h00010001) begin failed++; $display("FAIL e_operand: got %h want 00010001", bus.operand); end
        repeat (2) @(negedge clk);
        tests++; if (bus.busy !== 1'b0 || bus.input_data_type !== 3'd0) begin failed++; $display("FAIL e_idle: busy=%b idt=%0d want 0/0", bus.busy, bus.input_data_type); end
    endtask

    task automatic test_timeout();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        tests++; if (bus_t.input_data_type !== 3'd1) begin failed++; $display("FAIL tmo_idt: got %0d want 1", bus_t.input_data_type); end
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            tests++;
            if (bus_t.error !== 1'b0 || bus_t.busy !== 1'b1) begin
                failed++;
                $display("FAIL tmo_wait_c%0d: error=%b busy=%b want 0/1", c, bus_t.error, bus_t.busy);
            end
        end
        @(negedge clk);
        tests++; if (bus_t.error !== 1'b1 || bus_t.err_code !== 2'b10) begin failed++; $display("FAIL tmo_pulse: error=%b code=%b want 1/10", bus_t.error, bus_t.err_code); end
        tests++; if (bus_t.busy !== 1'b0) begin failed++; $display("FAIL tmo_idle: busy=%b want 0", bus_t.busy); end
        @(negedge clk);
        tests++; if (bus_t.error !== 1'b0 || bus_t.err_code !== 2'b10) begin failed++; $display("FAIL tmo_sticky: error=%b code=%b want 0/10", bus_t.error, bus_t.err_code); end
        bus.done   = 1'b1;
        bus.result = 32'hDEADBEEF;
        @(negedge clk);
        bus.done   = 1'b0;
        bus.result = 32'h0;
        for (int c = 0; c < 6; c++) begin
            tests++;
            if (bus_t.out_valid !== 1'b0 || bus_t.busy !== 1'b0) begin
                failed++;
                $display("FAIL tmo_spurious%0d: out_valid=%b busy=%b want 0/0", c, bus_t.out_valid, bus_t.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        rst_n = 1'b0;
        #1;
        tests++; if (bus.operand !== 32'h0 || bus.input_data_type !== 3'd0) begin failed++; $display("FAIL mid_rst_data: operand=%h idt=%0d want 0/0", bus.operand, bus.input_data_type); end
        tests++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failed++; $display("FAIL mid_rst_ctrl: in_ready=%b busy=%b out_valid=%b want 0/0/0", bus.in_ready, bus.busy, bus.out_valid); end
        tests++; if (bus.error !== 1'b0 || bus.err_code !== 2'b00) begin failed++; $display("FAIL mid_rst_err: error=%b code=%b want 0/00", bus.error, bus.err_code); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        tests++; if (bus.input_data_type !== 3'd2) begin failed++; $display("FAIL mid_idt_t1: got %0d want 2", bus.input_data_type); end
        tests++; if (bus.operand !== 32'hAABBCCDD) begin failed++; $display("FAIL mid_operand: got %h want aabbccdd", bus.operand); end
        @(negedge clk);
        tests++; if (bus.input_data_type !== 3'd0) begin failed++; $display("FAIL mid_idt_t2: got %0d want 0", bus.input_data_type); end
        @(negedge clk);
        tests++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin failed++; $display("FAIL mid_idle_t3: busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready); end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_byte   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.done      = 1'b0;
        bus.result    = 32'h0;
        test_reset();
        test_n_load();
        test_message();
        test_backpressure();
        test_bad_header();
        test_timeout();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
